seven_seg_scanner: RTL

- Parametrised time-multiplexed seven-segment driver for NUM_DIGITS hex digits.
- Successor to the fixed 4-digit display path.
- Adds:
  - frame-synchronous double-buffering of digit data (no tearing)
  - per-digit decimal point and explicit blanking
  - leading-zero suppression
  - PWM brightness control
  - configurable anode/cathode polarity
- Sits between the datapath result registers and the board's anode/cathode pins.

---
 rtl/seven_seg_scanner_if.sv | 26 ++
 rtl/seven_seg_scanner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// Digit data in and pin drive out for the multiplexed seven-segment scanner.
// The source of the digit data drives the master side; the scanner uses the slave side.
interface seven_seg_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic [BRIGHT_W-1:0]     brightness;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              ca;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output digits, dp_in, blank_in, lz_en, brightness,
        input  an, ca, dp, frame_start
    );

    modport slave (
        input  digits, dp_in, blank_in, lz_en, brightness,
        output an, ca, dp, frame_start
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex seven-segment driver with frame-synchronous digit buffering,
// leading-zero suppression, per-digit blanking and PWM brightness.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SRC_FREQ      = 100000000,
    parameter int unsigned SCAN_FREQ     = 100000,
    parameter int unsigned BRIGHT_W      = 4,
    parameter int unsigned AN_ACTIVE_LOW = 1,
    parameter int unsigned CA_ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              clr,
    seven_seg_scanner_if.slave bus
);
    localparam int unsigned DIV   = SRC_FREQ / SCAN_FREQ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
    localparam bit          AN_POL = (AN_ACTIVE_LOW != 0);
    localparam bit          CA_POL = (CA_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]      cnt;
    logic [SEL_W-1:0]      sel;
    logic [BRIGHT_W-1:0]   pwm;
    logic [3:0]            sh_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [NUM_DIGITS-1:0] sh_blank;
    logic                  sh_lz;

    logic                  tick_c;
    logic                  wrap_c;
    logic                  run_c;
    logic [NUM_DIGITS-1:0] supp_c;
    logic                  lit_c;
    logic [NUM_DIGITS-1:0] an_act_c;
    logic [6:0]            seg_c;
    logic                  dp_act_c;
    logic [NUM_DIGITS-1:0] an_c;
    logic [6:0]            ca_c;
    logic                  dp_c;

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            ca_q;
    logic                  dp_q;
    logic                  fs_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h00;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign tick_c = (cnt == CNT_W'(DIV - 1));
    assign wrap_c = tick_c && (sel == SEL_W'(NUM_DIGITS - 1));

    // Scan divider, digit select, PWM counter and the frame shadow copy.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt      <= '0;
            sel      <= '0;
            pwm      <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) sh_dig[i] <= 4'h0;
        end else begin
            pwm <= pwm + BRIGHT_W'(1);
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
            if (tick_c) sel <= wrap_c ? '0 : sel + SEL_W'(1);
            if (wrap_c) begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) sh_dig[i] <= bus.digits[4*i +: 4];
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank_in;
                sh_lz    <= bus.lz_en;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        run_c  = sh_lz;
        supp_c = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            run_c     = run_c && (sh_dig[i] == 4'h0);
            supp_c[i] = run_c;
        end
    end

    // Pin values for the selected digit; blanking wins over everything.
    always_comb begin
        an_act_c = '0;
        seg_c    = 7'h00;
        dp_act_c = 1'b0;
        lit_c    = (bus.brightness == '1) || (pwm < bus.brightness);
        if (!sh_blank[sel]) begin
            if (lit_c)        an_act_c[sel] = 1'b1;
            if (!supp_c[sel]) seg_c = seg_decode(sh_dig[sel]);
            dp_act_c = sh_dp[sel];
        end
        an_c = an_act_c ^ {NUM_DIGITS{AN_POL}};
        ca_c = seg_c ^ {7{CA_POL}};
        dp_c = dp_act_c ^ CA_POL;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            an_q <= {NUM_DIGITS{AN_POL}};
            ca_q <= {7{CA_POL}};
            dp_q <= CA_POL;
            fs_q <= 1'b0;
        end else begin
            an_q <= an_c;
            ca_q <= ca_c;
            dp_q <= dp_c;
            fs_q <= wrap_c;
        end
    end

    assign bus.an          = an_q;
    assign bus.ca          = ca_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;
endmodule
